// File: rtl/mem_pkg.sv
// Shared types, byte-lane constants and lane helpers for the memory-access stage.
// Little-endian, 32-bit data path with four byte lanes.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memsize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Size code 2'b11 is illegal and falls through to word behaviour everywhere.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      BYTE:    return BE_BYTE << offset;
      HALF:    return offset[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      BYTE:    return {4{data[7:0]}};
      HALF:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/half from a memory word and sign- or zero-extends it.
// Purely combinational so it can also serve as a reference model.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] value
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Lane selection and extension.
  always_comb begin
    case (offset)
      2'b00:   lane_byte = word[7:0];
      2'b01:   lane_byte = word[15:8];
      2'b10:   lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
    lane_half = offset[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE:    value = is_unsigned ? {24'h000000, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      HALF:    value = is_unsigned ? {16'h0000, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: drives a request/ready data-memory port, formats stores, aligns loads
// and stalls the upstream pipeline until each access completes.
module mem_access
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  memsize,
  input  logic        memunsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  mem_state_t  state_r;
  mem_state_t  next_state;
  logic        access;
  logic        bad_align;
  logic        start;
  logic        capture;
  logic [1:0]  offset_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic        load_r;
  logic [31:0] aligned;

  assign access    = memread | memwrite;
  assign bad_align = is_misaligned(memsize, addr[1:0]);

  // Extraction uses the offset/size latched at request time, not the live inputs.
  load_align u_load_align (
    .word        (dmem_rdata),
    .offset      (offset_r),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .value       (aligned)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  // Next-state logic; DONE never starts a new access since the inputs are stale.
  always_comb begin
    next_state = state_r;
    case (state_r)
      IDLE:    next_state = (access && !bad_align) ? REQ : IDLE;
      REQ:     next_state = dmem_ready ? DONE : REQ;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: stall, misalign flag, and load/capture strobes.
  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    start    = 1'b0;
    capture  = 1'b0;
    case (state_r)
      IDLE: begin
        misalign = access & bad_align;
        if (access && !bad_align) begin
          stall = 1'b1;
          start = 1'b1;
        end else begin
          stall = 1'b0;
          start = 1'b0;
        end
      end
      REQ: begin
        stall   = 1'b1;
        capture = dmem_ready;
      end
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Bus registers and latched access attributes; held stable through REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h0000_0000;
      offset_r   <= 2'b00;
      size_r     <= 2'b00;
      unsigned_r <= 1'b0;
      load_r     <= 1'b0;
    end else if (start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= memwrite;
      dmem_addr  <= {addr[31:2], 2'b00};
      dmem_be    <= byte_enables(memsize, addr[1:0]);
      dmem_wdata <= store_lanes(memsize, wdata);
      offset_r   <= addr[1:0];
      size_r     <= memsize;
      unsigned_r <= memunsigned;
      load_r     <= memread & ~memwrite;
    end else if (capture) begin
      dmem_req   <= 1'b0;
    end
  end

  // Load result register; stores and idle cycles leave it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'h0000_0000;
    end else if (capture && load_r) begin
      readdata <= aligned;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stimulus pushes hand-computed expectations into a
// scoreboard queue; a monitor pops and checks at each handshake and DONE cycle.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, memunsigned;
  logic [1:0]  memsize;
  logic [31:0] addr, wdata;
  logic [31:0] readdata;
  logic        stall, misalign;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  logic        resp_ready = 1'b0;
  logic        pulse_ready = 1'b0;
  logic [31:0] resp_rdata = 32'h0000_0000;
  int          ready_delay = 0;
  int          wait_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  assign dmem_ready = resp_ready | pulse_ready;
  assign dmem_rdata = resp_rdata;

  always #5 clk = ~clk;

  mem_access dut (
    .clk         (clk),
    .reset       (reset),
    .memread     (memread),
    .memwrite    (memwrite),
    .memsize     (memsize),
    .memunsigned (memunsigned),
    .addr        (addr),
    .wdata       (wdata),
    .readdata    (readdata),
    .stall       (stall),
    .misalign    (misalign),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ready  (dmem_ready),
    .dmem_rdata  (dmem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Memory responder: raises ready after ready_delay extra REQ cycles.
  initial begin : responder
    forever begin
      @(posedge clk);
      #2;
      if (dmem_req) begin
        if (wait_cnt >= ready_delay) resp_ready = 1'b1;
        else wait_cnt++;
      end else begin
        resp_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: stability while requesting, bus fields at handshake, result in DONE.
  exp_t        cur;
  bit          in_req = 1'b0;
  bit          done_pend = 1'b0;
  int          stall_cnt = 0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        in_req = 1'b0;
        done_pend = 1'b0;
        stall_cnt = 0;
      end else if (done_pend) begin
        check("done_stall", {31'b0, stall}, 32'd0);
        check("readdata", readdata, cur.rd);
        check("stall_cycles", 32'(stall_cnt), 32'(cur.stalls));
        done_pend = 1'b0;
        stall_cnt = 0;
      end else begin
        if (stall) stall_cnt++;
        if (dmem_req) begin
          if (!in_req) begin
            in_req = 1'b1;
            s_addr = dmem_addr; s_wdata = dmem_wdata; s_be = dmem_be; s_we = dmem_we;
          end else begin
            check("stable_addr", dmem_addr, s_addr);
            check("stable_bus", {dmem_wdata[27:0], dmem_be}, {s_wdata[27:0], s_be});
            check("stable_we", {31'b0, dmem_we}, {31'b0, s_we});
          end
          if (dmem_ready) begin
            in_req = 1'b0;
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_handshake: addr 0x%h with empty scoreboard", dmem_addr);
            end else begin
              cur = sb.pop_front();
              check("dmem_addr", dmem_addr, cur.addr);
              check("dmem_we", {31'b0, dmem_we}, {31'b0, cur.we});
              check("dmem_be", {28'b0, dmem_be}, {28'b0, cur.be});
              check("dmem_wdata", dmem_wdata, cur.wdata);
              done_pend = 1'b1;
            end
          end
        end
      end
    end
  end

  // Issue one access (called at posedge+1) and hold it until the pipeline advances.
  task automatic access(input logic rd, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rword, input int delay, input exp_t e);
    int t = 0;
    sb.push_back(e);
    ready_delay = delay;
    resp_rdata  = rword;
    memread = rd; memwrite = wr; memsize = size; memunsigned = uns; addr = a; wdata = wd;
    do begin
      @(negedge clk);
      t++;
    end while (!(dmem_req && dmem_ready) && t < 200);
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: addr 0x%h got no handshake, expected one", a);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  // Misaligned access: flag only, no request, no stall, result untouched.
  task automatic misaligned(input logic wr, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] keep_rd);
    memread = ~wr; memwrite = wr; memsize = size; memunsigned = 1'b0; addr = a;
    wdata = 32'h55AA_55AA;
    repeat (3) begin
      @(negedge clk);
      check("misalign", {31'b0, misalign}, 32'd1);
      check("misalign_stall", {31'b0, stall}, 32'd0);
      check("misalign_req", {31'b0, dmem_req}, 32'd0);
      check("misalign_readdata", readdata, keep_rd);
    end
    @(posedge clk);
    #1;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset = 1'b1;
    memread = 1'b0; memwrite = 1'b0; memsize = 2'b10; memunsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_bus", {dmem_req, dmem_we, dmem_be, stall, misalign}, 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    //      rd    wr    size   uns   addr          wdata         rword         dly  {addr, we, be, wdata, rd, stalls}
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, '{32'h100, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 2});
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h301, 32'h0, 32'h8899AABB, 0, '{32'h300, 1'b0, 4'b0010, 32'h0, 32'hFFFFFFAA, 2});
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h301, 32'h0, 32'h8899AABB, 0, '{32'h300, 1'b0, 4'b0010, 32'h0, 32'h000000AA, 2});
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 32'h8899AABB, 0, '{32'h300, 1'b0, 4'b1100, 32'h0, 32'hFFFF8899, 2});
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h8899AABB, 0, '{32'h300, 1'b0, 4'b1100, 32'h0, 32'h00008899, 2});
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 32'h8899AABB, 0, '{32'h300, 1'b0, 4'b0001, 32'h0, 32'hFFFFFFBB, 2});
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h303, 32'h0, 32'h8899AABB, 0, '{32'h300, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF88, 2});
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 32'h8899AABB, 0, '{32'h300, 1'b0, 4'b0011, 32'h0, 32'h0000AABB, 2});
    // Stores: the memory returns garbage on rdata, which must not reach readdata.
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h203, 32'h12345678, 32'hFFFFFFFF, 0, '{32'h200, 1'b1, 4'b1000, 32'h78787878, 32'h0000AABB, 2});
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h12345678, 32'hFFFFFFFF, 0, '{32'h200, 1'b1, 4'b1100, 32'h56785678, 32'h0000AABB, 2});
    // Ready arrives on the fifth REQ cycle: six stall cycles.
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h01234567, 4, '{32'h104, 1'b0, 4'b1111, 32'h0, 32'h01234567, 6});
    misaligned(1'b0, 2'b10, 32'h102, 32'h01234567);
    misaligned(1'b1, 2'b01, 32'h101, 32'h01234567);
    // Read and write together: the write wins, no load result.
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 32'h11111111, 1, '{32'h400, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h01234567, 3});
    // Illegal size code behaves as a word.
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h108, 32'h0, 32'h0A0B0C0D, 0, '{32'h108, 1'b0, 4'b1111, 32'h0, 32'h0A0B0C0D, 2});

    // Reset while in REQ, with a ready that never comes from the responder.
    ready_delay = 1000;
    memread = 1'b1; memwrite = 1'b0; memsize = 2'b10; addr = 32'h10C;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_req", {31'b0, dmem_req}, 32'd0);
    check("midrst_readdata", readdata, 32'h0);
    memread = 1'b0;
    pulse_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("postrst_req", {31'b0, dmem_req}, 32'd0);
    check("postrst_stall", {31'b0, stall}, 32'd0);
    check("postrst_readdata", readdata, 32'h0);
    @(posedge clk);
    #1 pulse_ready = 1'b0;
    @(negedge clk);
    check("late_ready_readdata", readdata, 32'h0);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, '{32'h100, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 2});

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the pipelined MIPS core, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns the EX/MEM load/store control and address/data into a request/ready transaction on a variable-latency data-memory port. It formats stores into byte lanes, aligns and extends loads, and stalls the pipeline until each access completes. Its `readdata` output feeds the MEM/WB register's read-data input directly.

## Interface
Parameters:
- none; width fixed at 32 bits, 4 byte lanes.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `memread`  in  1  load in EX/MEM
- `memwrite`  in  1  store in EX/MEM
- `memsize`  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as word)
- `memunsigned`  in  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0
- `addr`  in  32  byte address from ALU
- `wdata`  in  32  store data (rt)
- `readdata`  out  32  aligned/extended load result to MEM/WB
- `stall`  out  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB not required (MEM/WB holds)
- `misalign`  out  1  address-error flag for current access
- `dmem_req`  out  1  bus request, registered
- `dmem_we`  out  1  write request, registered
- `dmem_addr`  out  32  word address (`addr[31:2]`, 2'b00), registered
- `dmem_be`  out  4  byte enables, registered
- `dmem_wdata`  out  32  lane-replicated store data, registered
- `dmem_ready`  in  1  memory completes the access this cycle
- `dmem_rdata`  in  32  read word, valid when `dmem_ready`

## Operation
- Access = `memread | memwrite`. If both are high, the write wins and no load result is produced.
- Misaligned: half with `addr[0]=1`, or word with `addr[1:0]!=0`. `misalign` is combinational in IDLE. No bus request, no stall, store suppressed, `readdata` unchanged.
- FSM states:
  - **IDLE**: aligned access → load bus registers, go to REQ, `stall=1`. Otherwise stay, `stall=0`.
  - **REQ**: `dmem_req=1`, outputs held stable, `stall=1`. When `dmem_ready=1` → capture the load into `readdata` (loads only), drop `dmem_req`, go to DONE.
  - **DONE**: `stall=0`; the pipeline advances at this edge and MEM/WB latches `readdata`. Unconditionally → IDLE. No new access starts in DONE (the inputs are still the old instruction).
- Byte enables, little-endian:
  - byte: `4'b0001 << addr[1:0]`
  - half: `addr[1] ? 1100 : 0011`
  - word: `1111`
  - Loads use the same `dmem_be`.
- Store data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load extraction:
  - byte lane `addr[1:0]`, half lane `addr[1]`, each sign- or zero-extended per `memunsigned`.
  - `addr` and size are latched at REQ entry; extraction uses the latched copies.
- Stores never modify `readdata`. Non-memory instructions leave `readdata` holding its last value.
- `dmem_ready` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `readdata=0`, `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_be=0`, `dmem_wdata=0`. `stall` and `misalign` are 0 when no access is present.
- Minimum access: 3 cycles (IDLE, REQ with ready, DONE), i.e. 2 stall cycles. Each extra wait cycle of `dmem_ready=0` adds one stall cycle.
- `stall` is combinational from state and inputs, valid in the same cycle the access appears.
- Back-to-back accesses: each takes ≥3 cycles, with no overlap.
- Reset mid-access (REQ) forces IDLE and drops `dmem_req` asynchronously. A late `dmem_ready` is ignored and `readdata` is 0.

## Structure
- Package `mem_pkg`: `memsize_t` enum (BYTE, HALF, WORD), `mem_state_t` enum (IDLE, REQ, DONE), lane/BE constants.
- Sub-module `load_align`: combinational; inputs word, offset, size, unsigned; output extended 32-bit value. It is reused by the verification model.

## Test plan
- Reset, then lw at `0x100`, ready on the first REQ cycle, rdata `0xDEADBEEF` → `stall` high for 2 cycles, `dmem_addr=0x100`, `be=1111`, `readdata=0xDEADBEEF` in DONE.
- Reading word `0x8899AABB`:
  - lb at `addr=...1` → `0xFFFFFFAA`.
  - lbu at `addr=...1` → `0x000000AA`.
  - lh at `addr=...2` → `0xFFFF8899`.
  - lhu at `addr=...2` → `0x00008899`.
- sb `wdata=0x12345678` at `addr=0x203` → `dmem_we=1`, `be=1000`, `dmem_wdata=0x78787878`, `dmem_addr=0x200`. sh at `0x202` → `be=1100`, `wdata=0x56785678`.
- lw with ready delayed 5 cycles → `stall` high for 6 cycles, bus outputs stable throughout, single capture.
- lw at `0x102`, then sh at `0x101` → `misalign=1`, `stall=0`, `dmem_req` never asserted, `readdata` unchanged.
- Reset asserted in REQ, then `dmem_ready` pulses → `dmem_req=0` immediately, state IDLE, `readdata=0`.
